md_unit: RTL and testbench

- Multi-cycle multiply/divide unit with HI/LO registers for the E stage of the pipelined MIPS core.
- Accepts one operation per request and holds busy for a fixed, parametrised latency.
- Commits results to HI/LO atomically when the operation completes.
- Exposes a stall request so the D-stage hazard unit can hold mult/div/mfhi/mflo/mthi/mtlo instructions while an operation is in flight.

---
 rtl/md_unit.sv | 88 ++++++++
 tb/tb_md_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Defining MD_CANCEL_EN adds a cancel input that aborts an in-flight op and blocks acceptance.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
`ifdef MD_CANCEL_EN
    input  logic             cancel,
`endif
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0]      cnt;
    logic [2:0]         op;
    logic [WIDTH-1:0]   a, b, bd, q_s, r_s, q_u, r_u, res_hi, res_lo;
    logic [2*WIDTH-1:0] prod;
    logic               kill, req_md, is_div, div_zero, ovf, done;

`ifdef MD_CANCEL_EN
    assign kill = cancel;
`else
    assign kill = 1'b0;
`endif

    assign req_md    = md_op >= 3'd1 && md_op <= 3'd4;
    assign stall_req = busy | req_md;
    assign is_div    = op == 3'd3 || op == 3'd4;
    assign div_zero  = b == '0;
    assign ovf       = op == 3'd3 && a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1;
    assign done      = busy && !kill && cnt == '0;

    // Dividing by one on overflow yields exactly the required most-negative quotient and zero remainder.
    assign bd   = (div_zero || ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
    assign q_s  = $signed(a) / $signed(bd);
    assign r_s  = $signed(a) % $signed(bd);
    assign q_u  = a / bd;
    assign r_u  = a % bd;
    assign prod = op == 3'd1 ? {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b}
                             : {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    assign res_hi = is_div ? (op == 3'd3 ? r_s : r_u) : prod[2*WIDTH-1:WIDTH];
    assign res_lo = is_div ? (op == 3'd3 ? q_s : q_u) : prod[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0;
            cnt  <= '0;
            op   <= '0;
            a    <= '0;
            b    <= '0;
            hi   <= '0;
            lo   <= '0;
        end else if (busy) begin
            if (kill || cnt == '0) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else
                cnt <= cnt - CW'(1);
            if (done && !(is_div && div_zero)) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end else if (!kill) begin
            if (req_md) begin
                busy <= 1'b1;
                op   <= md_op;
                a    <= rs_val;
                b    <= rt_val;
                cnt  <= md_op >= 3'd3 ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
            end
            if (md_op == 3'd5)
                hi <= rs_val;
            if (md_op == 3'd6)
                lo <= rs_val;
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit; commits are checked by a monitor against queued expectations.
module tb_md_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] rs_val = '0, rt_val = '0;
    logic        busy, stall_req;
    logic [31:0] hi, lo;
`ifdef MD_CANCEL_EN
    logic        cancel = 1'b0;
`endif

    md_unit dut (
        .clk(clk), .reset(rst_n), .md_op(md_op), .rs_val(rs_val), .rt_val(rt_val),
`ifdef MD_CANCEL_EN
        .cancel(cancel),
`endif
        .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] h;
        logic [31:0] l;
        int          n;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0;
    bit   abort_pending = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] h, input logic [31:0] l, input int n);
        exp_t e;
        e.h = h; e.l = l; e.n = n;
        sb.push_back(e);
    endtask

    task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        md_op = op; rs_val = a; rt_val = b;
        #1 chk("stall_on_accept", {31'd0, stall_req}, 32'd1);
    endtask

    task automatic idle();
        @(negedge clk);
        md_op = 3'd0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || sb.size() != 0) && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) begin
            checks++; errors++;
            $display("FAIL wait_idle timeout busy=%b pending=%0d required busy=0 pending=0", busy, sb.size());
        end
    endtask

    // Monitor: counts busy samples per op and compares hi/lo when busy falls.
    initial begin
        int   run;
        logic pb;
        exp_t e;
        run = 0; pb = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                run = 0; pb = 1'b0;
            end else begin
                if (busy) run++;
                else if (pb) begin
                    if (abort_pending) abort_pending = 1'b0;
                    else if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_commit hi=%h lo=%h required no commit", hi, lo);
                    end else begin
                        e = sb.pop_front();
                        chk("commit_hi", hi, e.h);
                        chk("commit_lo", lo, e.l);
                        chk("busy_cycles", run, e.n);
                    end
                    run = 0;
                end
                pb = busy;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_stall", {31'd0, stall_req}, 32'd0);
        // mult / multu
        push(32'hFFFFFFFF, 32'hFFFFFFFA, 5); start(3'd1, 32'hFFFFFFFE, 32'd3); idle(); wait_idle();
        push(32'hFFFFFFFE, 32'h00000001, 5); start(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF); idle(); wait_idle();
        // div, divide by zero leaves hi/lo, signed overflow
        push(32'hFFFFFFFF, 32'hFFFFFFFD, 10); start(3'd3, 32'hFFFFFFF9, 32'd2); idle(); wait_idle();
        push(32'hFFFFFFFF, 32'hFFFFFFFD, 10); start(3'd4, 32'd7, 32'd0); idle(); wait_idle();
        push(32'h00000000, 32'h80000000, 10); start(3'd3, 32'h80000000, 32'hFFFFFFFF); idle(); wait_idle();
        // mthi and operand changes during a mult are ignored
        push(32'h00000012, 32'h34567800, 5); start(3'd1, 32'h12345678, 32'h100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            md_op = 3'd5; rs_val = 32'h1234; rt_val = 32'hFFFF;
            #1 chk("stall_while_busy", {31'd0, stall_req}, 32'd1);
            chk("hi_held_while_busy", hi, 32'd0);
        end
        idle(); wait_idle();
        @(negedge clk); md_op = 3'd5; rs_val = 32'h1234;
        #1 chk("stall_mthi", {31'd0, stall_req}, 32'd0);
        idle();
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_lo_kept", lo, 32'h34567800);
        @(negedge clk); md_op = 3'd6; rs_val = 32'hBEEF;
        idle();
        chk("mtlo_lo", lo, 32'hBEEF);
        chk("mtlo_hi_kept", hi, 32'h1234);
        // more divides
        push(32'd2, 32'd14, 10); start(3'd4, 32'd100, 32'd7); idle(); wait_idle();
        push(32'd1, 32'hFFFFFFFD, 10); start(3'd3, 32'd7, 32'hFFFFFFFE); idle(); wait_idle();
        // back-to-back: next request held from the first busy cycle is taken after commit
        push(32'd0, 32'd12, 5); push(32'd0, 32'd1, 5);
        start(3'd2, 32'd3, 32'd4);
        @(negedge clk); md_op = 3'd1; rs_val = 32'hFFFFFFFF; rt_val = 32'hFFFFFFFF;
        begin
            int k;
            k = 0;
            while (busy && k < 20) begin @(negedge clk); k++; end
        end
        @(negedge clk); md_op = 3'd0;
        chk("b2b_accepted", {31'd0, busy}, 32'd1);
        wait_idle();
`ifdef MD_CANCEL_EN
        @(negedge clk); md_op = 3'd5; rs_val = 32'hAAAA;
        idle();
        start(3'd1, 32'd5, 32'd5); idle();
        @(negedge clk); cancel = 1'b1; abort_pending = 1'b1;
        @(negedge clk); cancel = 1'b0;
        chk("cancel_busy", {31'd0, busy}, 32'd0);
        chk("cancel_hi", hi, 32'hAAAA);
        chk("cancel_lo", lo, 32'd1);
        @(negedge clk); md_op = 3'd5; rs_val = 32'h5555; cancel = 1'b1;
        @(negedge clk); md_op = 3'd1; cancel = 1'b1;
        @(negedge clk); md_op = 3'd0; cancel = 1'b0;
        chk("cancel_mthi_blocked", hi, 32'hAAAA);
        chk("cancel_accept_blocked", {31'd0, busy}, 32'd0);
`endif
        // asynchronous reset mid-divide discards the op
        start(3'd3, 32'd100, 32'd7); idle();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_busy", {31'd0, busy}, 32'd0);
        chk("async_reset_hi", hi, 32'd0);
        chk("async_reset_lo", lo, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("no_commit_after_reset_hi", hi, 32'd0);
        chk("no_commit_after_reset_lo", lo, 32'd0);
        chk("no_commit_after_reset_busy", {31'd0, busy}, 32'd0);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
